// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and defaults for the echo delay-line controller.
// The DELAY_FLUSH_EN macro (see delay_line_ctrl.sv) enables re-flush on delay change.
package delay_line_ctrl_pkg;

   localparam int DEPTH_DEF = 8192;
   localparam int CNT_W_DEF = 14;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

   // Zero delay would never leave PRIME; anything past DEPTH-1 would overfill the FIFO.
   function automatic logic [31:0] clamp_delay(input logic [31:0] d, input int unsigned depth);
      if (d == 32'd0) return 32'd1;
      if (d > depth - 32'd1) return depth - 32'd1;
      return d;
   endfunction

endpackage

// File: rtl/delay_line_ctrl_fill_counter.sv
// Fill counter for the delay-line FIFO: counts priming writes and flags when the
// occupancy has reached the latched delay target.
module delay_fill_counter #(
   parameter int CNT_W = 14
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] target_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             reached_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A clear and an increment together land on 1: the first priming write.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = inc_i ? CNT_W'(1) : '0;
      else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o     = cnt_q;
   assign reached_o = (cnt_q == target_i);

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequencer for the echo delay-line FIFO: flush, prime to delay D, then run.
// Define DELAY_FLUSH_EN to re-flush and re-prime whenever delay_len changes.
module delay_line_ctrl
   import delay_line_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             sample_strobe,
   input  logic [CNT_W-1:0] delay_len,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   output logic             wrreq,
   output logic             rdreq,
   output logic             echo_en,
   output logic [CNT_W-1:0] fill,
   output logic             err
);

   state_e           state_q, state_d;
   logic             wr_q, wr_d, rd_q, rd_d, echo_q, echo_d, err_q, err_d;
   logic             emp_q, emp_d;
   logic             clr, inc, load, reached;
   logic [CNT_W-1:0] delay_q, dclamp;

   assign dclamp = CNT_W'(clamp_delay(32'(delay_len), DEPTH));

   delay_fill_counter #(.CNT_W(CNT_W)) u_fill (
      .clk_i    (sysclk),
      .rst_i    (rst),
      .clr_i    (clr),
      .inc_i    (inc),
      .target_i (delay_q),
      .cnt_o    (fill),
      .reached_o(reached)
   );

   always_comb begin
      state_d = state_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      err_d   = err_q;
      emp_d   = 1'b0;
      clr     = 1'b0;
      inc     = 1'b0;
      load    = 1'b0;
      case (state_q)
         FLUSH: begin
            rd_d  = !fifo_empty;
            emp_d = fifo_empty;
            if (fifo_empty && emp_q) begin
               state_d = PRIME;
               clr     = 1'b1;
               load    = 1'b1;
            end
         end
         PRIME:   if (reached) state_d = RUN;
         default: ;
      endcase
`ifdef DELAY_FLUSH_EN
      if (state_q != FLUSH && dclamp != delay_q) state_d = FLUSH;
`endif
      // The strobe follows the rules of the state being entered this edge.
      if (sample_strobe) begin
         if (state_d == PRIME) begin
            if (fifo_full) begin
               err_d   = 1'b1;
               state_d = FLUSH;
            end else begin
               wr_d = 1'b1;
               inc  = 1'b1;
            end
         end else if (state_d == RUN) begin
            if (fifo_full || fifo_empty) begin
               err_d   = 1'b1;
               state_d = FLUSH;
            end else begin
               wr_d = 1'b1;
               rd_d = 1'b1;
            end
         end
      end
      echo_d = (state_d == RUN) && (echo_q || rd_d);
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q <= FLUSH;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         echo_q  <= 1'b0;
         err_q   <= 1'b0;
         emp_q   <= 1'b0;
         delay_q <= CNT_W'(1);
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         echo_q  <= echo_d;
         err_q   <= err_d;
         emp_q   <= emp_d;
         if (load) delay_q <= dclamp;
      end
   end

   assign wrreq   = wr_q;
   assign rdreq   = rd_q;
   assign echo_en = echo_q;
   assign err     = err_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: FIFO occupancy model plus per-strobe expectations
// derived from the flush/prime/run rules.
module tb_delay_line_ctrl;

   localparam int DEPTH = 8192;

   logic        sysclk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_strobe = 1'b0;
   logic [13:0] delay_len = 14'd4;
   logic        fifo_empty, fifo_full;
   logic        wrreq, rdreq, echo_en, err;
   logic [13:0] fill;

   int  fifo_cnt = 0;
   int  preload_val = 0;
   bit  preload_req = 1'b0;
   bit  force_empty = 1'b0;
   int  full_seen = 0;
   int  vectors = 0;
   int  miscompares = 0;

   delay_line_ctrl dut (
      .sysclk       (sysclk),
      .rst          (rst),
      .sample_strobe(sample_strobe),
      .delay_len    (delay_len),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .wrreq        (wrreq),
      .rdreq        (rdreq),
      .echo_en      (echo_en),
      .fill         (fill),
      .err          (err)
   );

   always #5 sysclk = ~sysclk;

   assign fifo_empty = force_empty || (fifo_cnt == 0);
   assign fifo_full  = (fifo_cnt >= DEPTH);

   // Behavioural FIFO: writes ignored when full, reads ignored when empty.
   always @(posedge sysclk) begin
      if (preload_req) fifo_cnt <= preload_val;
      else fifo_cnt <= fifo_cnt + ((wrreq && fifo_cnt < DEPTH) ? 1 : 0)
                                - ((rdreq && fifo_cnt > 0) ? 1 : 0);
      if (fifo_full) full_seen <= full_seen + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic pulse(input int gap, output logic w, output logic r, output logic e,
                        output logic [13:0] f, output logic w2, output logic r2);
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      w = wrreq; r = rdreq; e = echo_en; f = fill;
      tick();
      w2 = wrreq; r2 = rdreq;
      repeat (gap - 2) tick();
   endtask

   task automatic wait_flushed();
      int n = 0;
      while (fifo_cnt != 0 && n < 20000) begin tick(); n++; end
      vectors++;
      if (n >= 20000) begin miscompares++; $display("FAIL flush_timeout: fifo words %0d, exp 0", fifo_cnt); end
      repeat (4) tick();
   endtask

   task automatic restart(input logic [13:0] dl);
      rst = 1'b1; delay_len = dl;
      tick();
      rst = 1'b0;
      wait_flushed();
   endtask

   // Expected outcome of strobe k with effective delay d, checked in one place per scenario.
   task automatic test_reset();
      int rd_hi = 0, wr_hi = 0, echo_hi = 0;
      rst = 1'b1; preload_val = 5; preload_req = 1'b1;
      tick();
      preload_req = 1'b0;
      tick();
      vectors++; if (wrreq !== 1'b0)   begin miscompares++; $display("FAIL reset_wrreq got %b exp 0", wrreq); end
      vectors++; if (rdreq !== 1'b0)   begin miscompares++; $display("FAIL reset_rdreq got %b exp 0", rdreq); end
      vectors++; if (echo_en !== 1'b0) begin miscompares++; $display("FAIL reset_echo got %b exp 0", echo_en); end
      vectors++; if (fill !== 14'd0)   begin miscompares++; $display("FAIL reset_fill got %0d exp 0", fill); end
      vectors++; if (err !== 1'b0)     begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         sample_strobe = (i == 1);
         tick();
         rd_hi += int'(rdreq); wr_hi += int'(wrreq); echo_hi += int'(echo_en);
      end
      sample_strobe = 1'b0;
      vectors++; if (fifo_cnt != 0) begin miscompares++; $display("FAIL flush_words left %0d exp 0", fifo_cnt); end
      vectors++; if (rd_hi < 5 || rd_hi > 6) begin miscompares++; $display("FAIL flush_rdreq cycles %0d exp 5..6", rd_hi); end
      vectors++; if (wr_hi != 0) begin miscompares++; $display("FAIL flush_wrreq cycles %0d exp 0", wr_hi); end
      vectors++; if (echo_hi != 0) begin miscompares++; $display("FAIL flush_echo cycles %0d exp 0", echo_hi); end
      vectors++; if (fill !== 14'd0) begin miscompares++; $display("FAIL flush_fill got %0d exp 0", fill); end
   endtask

   task automatic run_strobes(input string tag, input int d, input int n, input int gmin, input int gmax);
      logic w, r, e, w2, r2;
      logic [13:0] f;
      for (int k = 1; k <= n; k++) begin
         logic exp_r;
         int   exp_f;
         pulse(int'($urandom_range(gmin, gmax)), w, r, e, f, w2, r2);
         exp_r = (k > d);
         exp_f = (k < d) ? k : d;
         vectors++; if (w !== 1'b1)  begin miscompares++; $display("FAIL %s_wr k=%0d got %b exp 1", tag, k, w); end
         vectors++; if (r !== exp_r) begin miscompares++; $display("FAIL %s_rd k=%0d got %b exp %b", tag, k, r, exp_r); end
         vectors++; if (e !== exp_r) begin miscompares++; $display("FAIL %s_echo k=%0d got %b exp %b", tag, k, e, exp_r); end
         vectors++; if (f !== 14'(exp_f)) begin miscompares++; $display("FAIL %s_fill k=%0d got %0d exp %0d", tag, k, f, exp_f); end
         vectors++; if (w2 !== 1'b0 || r2 !== 1'b0) begin miscompares++; $display("FAIL %s_width k=%0d got wr%b rd%b exp 00", tag, k, w2, r2); end
      end
   endtask

   task automatic test_prime_run();
      run_strobes("d4", 4, 6, 10, 10);
      vectors++; if (fifo_cnt != 4) begin miscompares++; $display("FAIL d4_words got %0d exp 4", fifo_cnt); end
      vectors++; if (err !== 1'b0)  begin miscompares++; $display("FAIL d4_err got %b exp 0", err); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         int dl, d;
         dl = int'($urandom_range(0, 24));
         d  = (dl == 0) ? 1 : dl;
         restart(14'(dl));
         run_strobes("rand", d, d + 3, 2, 9);
         vectors++; if (fifo_cnt != d) begin miscompares++; $display("FAIL rand_words got %0d exp %0d", fifo_cnt, d); end
      end
   endtask

   task automatic test_boundary();
      logic [13:0] dls [2];
      int fs0;
      restart(14'd0);
      run_strobes("d0", 1, 3, 2, 5);
      dls[0] = 14'd8191; dls[1] = 14'h3FFF;
      for (int j = 0; j < 2; j++) begin
         restart(dls[j]);
         fs0 = full_seen;
         run_strobes("dmax", 8191, 8192, 2, 2);
         vectors++; if (full_seen != fs0) begin miscompares++; $display("FAIL dmax_full cycles %0d exp 0", full_seen - fs0); end
         vectors++; if (fifo_cnt != 8191) begin miscompares++; $display("FAIL dmax_words got %0d exp 8191", fifo_cnt); end
      end
   endtask

   task automatic test_delay_change();
      logic w, r, e, w2, r2;
      logic [13:0] f;
      restart(14'd4);
      run_strobes("chg_pre", 4, 5, 6, 6);
      delay_len = 14'd6;
      tick();
`ifdef DELAY_FLUSH_EN
      vectors++; if (echo_en !== 1'b0) begin miscompares++; $display("FAIL chg_echo got %b exp 0", echo_en); end
      wait_flushed();
      run_strobes("chg_post", 6, 7, 3, 8);
`else
      vectors++; if (echo_en !== 1'b1) begin miscompares++; $display("FAIL chg_echo got %b exp 1", echo_en); end
      pulse(6, w, r, e, f, w2, r2);
      vectors++; if (w !== 1'b1 || r !== 1'b1) begin miscompares++; $display("FAIL chg_req got wr%b rd%b exp 11", w, r); end
      vectors++; if (f !== 14'd4) begin miscompares++; $display("FAIL chg_fill got %0d exp 4", f); end
      vectors++; if (fifo_cnt != 4) begin miscompares++; $display("FAIL chg_words got %0d exp 4", fifo_cnt); end
`endif
   endtask

   task automatic test_underflow();
      logic w, r, e, w2, r2;
      logic [13:0] f;
      restart(14'd2);
      run_strobes("uf_pre", 2, 3, 4, 4);
      force_empty = 1'b1;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0; force_empty = 1'b0;
      vectors++; if (rdreq !== 1'b0) begin miscompares++; $display("FAIL uf_rdreq got %b exp 0", rdreq); end
      vectors++; if (err !== 1'b1)   begin miscompares++; $display("FAIL uf_err got %b exp 1", err); end
      vectors++; if (echo_en !== 1'b0) begin miscompares++; $display("FAIL uf_echo got %b exp 0", echo_en); end
      wait_flushed();
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL uf_err_sticky got %b exp 1", err); end
      pulse(4, w, r, e, f, w2, r2);
      vectors++; if (w !== 1'b1 || r !== 1'b0) begin miscompares++; $display("FAIL uf_reprime got wr%b rd%b exp 10", w, r); end
      vectors++; if (f !== 14'd1) begin miscompares++; $display("FAIL uf_refill got %0d exp 1", f); end
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL uf_err_hold got %b exp 1", err); end
      rst = 1'b1;
      tick();
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL uf_err_clear got %b exp 0", err); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic w, r, e, w2, r2;
      logic [13:0] f;
      restart(14'd5);
      run_strobes("mid", 5, 2, 4, 4);
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      vectors++; if (wrreq !== 1'b1 || fill !== 14'd3) begin miscompares++; $display("FAIL mid_pre got wr%b fill%0d exp wr1 fill3", wrreq, fill); end
      #2 rst = 1'b1;
      #1;
      vectors++; if ({wrreq, rdreq, echo_en, err} !== 4'b0) begin miscompares++; $display("FAIL mid_outs got %b exp 0000", {wrreq, rdreq, echo_en, err}); end
      vectors++; if (fill !== 14'd0) begin miscompares++; $display("FAIL mid_fill got %0d exp 0", fill); end
      tick();
      vectors++; if (fifo_cnt != 2) begin miscompares++; $display("FAIL mid_dropped words %0d exp 2", fifo_cnt); end
      rst = 1'b0;
      wait_flushed();
      pulse(4, w, r, e, f, w2, r2);
      vectors++; if (w !== 1'b1 || r !== 1'b0 || f !== 14'd1) begin miscompares++; $display("FAIL mid_restart got wr%b rd%b fill%0d exp wr1 rd0 fill1", w, r, f); end
   endtask

   initial begin
      test_reset();
      test_prime_run();
      test_random();
      test_delay_change();
      test_underflow();
      test_reset_mid();
      test_boundary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencing controller for the 8192×10 echo delay-line FIFO in the audio processor. It turns the one-cycle sample strobe from the pulse generator into FIFO write/read requests and primes the FIFO to a programmable delay length instead of relying on the FIFO full flag. It flushes the FIFO after reset (and, optionally, on delay change) and tells the output mixer when the delayed sample is valid to mix.

## Interface
- DEPTH, 8192: FIFO word capacity.
- CNT_W, 14: width of fill counter and delay length; holds 0..DEPTH-1.
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse per new ADC sample.
- delay_len  in  CNT_W  requested delay, in samples.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- wrreq  out  1  FIFO write request, one cycle wide.
- rdreq  out  1  FIFO read request, one cycle wide.
- echo_en  out  1  high only when the FIFO output is a valid delayed sample.
- fill  out  CNT_W  current FIFO occupancy as tracked by the controller.
- err  out  1  sticky error flag: overflow or underflow detected.

## Operation
- States: FLUSH, PRIME, RUN. Reset enters FLUSH; the FIFO has no reset, so its contents are unknown.
- Effective delay D:
  - D = delay_len clamped to the range 1..DEPTH-1.
  - D is latched into delay_q on entry to PRIME.
- FLUSH:
  - rdreq = !fifo_empty every cycle.
  - sample_strobe is ignored.
  - Exit to PRIME when fifo_empty has been high for 2 consecutive cycles.
  - fill is forced to 0 on exit.
- PRIME:
  - Each strobe asserts wrreq only, and fill increments.
  - When fill reaches delay_q, go to RUN.
- RUN:
  - Each strobe asserts wrreq and rdreq together, so fill stays constant at delay_q.
- echo_en is registered: high in RUN only, and low from the first cycle of FLUSH or PRIME.
- Errors (err is sticky, cleared only by rst):
  - wrreq while fifo_full: set err, suppress the write, go to FLUSH.
  - rdreq in RUN while fifo_empty: set err, suppress the read, go to FLUSH.
- Outputs are registered; there is no combinational path from any input to any output.

## Timing
- Reset values:
  - wrreq=0, rdreq=0, echo_en=0, fill=0, err=0.
  - State is FLUSH.
- Request latency:
  - Strobe in cycle n gives wrreq/rdreq high in cycle n+1 only.
  - fill updates at the same edge that asserts wrreq.
- PRIME→RUN: on the edge after the strobe that makes fill == delay_q. echo_en rises together with the first RUN rdreq.
- Strobe in the same cycle as a state transition is applied using the new state's rules.
- Strobe spacing is at least 2 cycles; closer strobes are a system error and are not detected.
- Reset mid-operation:
  - Requests stop immediately.
  - An in-flight request that was registered is dropped.
  - The FIFO is re-flushed after reset deasserts.

## Configuration
- DELAY_FLUSH_EN defined:
  - delay_len is compared with delay_q every cycle in PRIME and RUN.
  - Any difference enters FLUSH on the next cycle, then PRIME with the new D.
  - Re-flush costs about fill+2 cycles plus D strobe periods of muted echo.
- DELAY_FLUSH_EN undefined:
  - delay_len is sampled only on PRIME entry.
  - Later changes are ignored until the next reset or error-induced FLUSH.

## Structure
- Shared package holds:
  - State encoding (FLUSH=2'd0, PRIME=2'd1, RUN=2'd2).
  - DEPTH and CNT_W defaults.
  - A clamp helper for delay_len.
- One sub-module, delay_fill_counter: up-counter with synchronous clear and load-compare against delay_q, producing the reached flag.
- The FSM, request registers and error logic stay in the top module.

## Test plan
- Reset with FIFO model pre-loaded with 5 words, fifo_empty=0 → rdreq high for 5 cycles, then fifo_empty high for 2 cycles, then PRIME; fill=0, echo_en=0.
- delay_len=4, strobes every 10 cycles → wrreq only on strobes 1–4, fill 1..4. Strobe 5 → wrreq and rdreq together, echo_en=1, fill stays 4.
- delay_len=0 → D=1; first strobe primes, second strobe gives wrreq+rdreq. delay_len=8191 → fill reaches 8191, fifo_full never asserted.
- DELAY_FLUSH_EN defined, RUN with D=4, delay_len changed to 6 → echo_en drops next cycle, 4 reads flush, then 6 priming writes, then RUN. Undefined: same change leaves RUN and fill=4 unchanged.
- Force fifo_empty=1 during RUN strobe → rdreq suppressed, err=1 held, FLUSH entered; err stays 1 until rst.
- Assert rst during PRIME at fill=3 → all outputs 0 immediately; after deassert, FLUSH runs, then priming restarts from 0.
